// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Holds the fetch PC and offers it to instruction memory over a valid/ready
// handshake. Redirects are applied in priority order: trap, branch, predicted
// return. Supports halt/resume.
// Optional feature: define PC_RAS_EN to build the return-address stack; when
// undefined the RAS inputs are ignored and ras_empty is tied high.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_target,
   input  logic            halt,
   output logic            misalign_err,
   input  logic            ras_push,
   input  logic [XLEN-1:0] ras_push_addr,
   input  logic            ras_pop,
   output logic            ras_empty
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALTED
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;

   // Redirect/update logic is live in every state except the boot cycle.
   logic            active;
   logic            ras_pop_take;
   logic [XLEN-1:0] ras_top_val;

   assign active       = (state_q != ST_BOOT);
   assign fetch_pc     = pc_q;
   assign pc_plus4     = pc_q + XLEN'(4);
   assign fetch_valid  = (state_q == ST_RUN);
   assign misalign_err = misalign_q;

`ifdef PC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
   logic [PW-1:0]   ras_top_q, ras_top_d;
   logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
   logic            ras_we;
   logic [PW-1:0]   ras_widx;

   assign ras_empty    = (ras_cnt_q == '0);
   assign ras_top_val  = ras_mem_q[ras_top_q];
   // A pop only wins when no trap or branch is asserted in the same cycle.
   assign ras_pop_take = active && ras_pop && !ras_empty && !trap_valid && !br_valid;

   // Stack pointer/count update and write-port selection.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      ras_top_d = ras_top_q;
      ras_cnt_d = ras_cnt_q;
      ras_we    = 1'b0;
      ras_widx  = ras_top_q;
      if (ras_pop_take && ras_push) begin
         // Call and return together: replace the top in place.
         ras_we = 1'b1;
      end else if (ras_pop_take) begin
         ras_top_d = ras_top_q - PW'(1);
         ras_cnt_d = ras_cnt_q - CW'(1);
      end else if (active && ras_push) begin
         // Circular push; when full this overwrites the oldest entry.
         ras_we    = 1'b1;
         ras_widx  = ras_top_q + PW'(1);
         ras_top_d = ras_top_q + PW'(1);
         if (ras_cnt_q != CW'(RAS_DEPTH)) begin
            ras_cnt_d = ras_cnt_q + CW'(1);
         end
      end
   end

   // Stack pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_top_q <= ras_top_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   // Stack storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; ras_cnt_q decides which entries are meaningful.
      if (ras_we) begin
         ras_mem_q[ras_widx] <= ras_push_addr;
      end
   end
`else
   logic unused_ras;

   assign ras_empty    = 1'b1;
   assign ras_top_val  = '0;
   assign ras_pop_take = 1'b0;
   assign unused_ras   = (^{ras_push, ras_push_addr, ras_pop}) ^ (RAS_DEPTH == 0);
`endif

   // Next state, next PC and misalignment flag.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;

      case (state_q)
         ST_BOOT:   state_d = ST_RUN;
         // In RUN the request is always valid, so it is only idle once accepted.
         ST_RUN:    if (halt && fetch_ready) state_d = ST_HALTED;
         ST_HALTED: if (!halt) state_d = ST_RUN;
         default:   state_d = ST_BOOT;
      endcase

      if (active) begin
         if (trap_valid) begin
            pc_d       = {trap_vector[XLEN-1:2], 2'b00};
            misalign_d = |trap_vector[1:0];
         end else if (br_valid) begin
            pc_d       = {br_target[XLEN-1:2], 2'b00};
            misalign_d = |br_target[1:0];
         end else if (ras_pop_take) begin
            pc_d = ras_top_val;
         end else if (fetch_valid && fetch_ready) begin
            pc_d = pc_plus4;
         end
      end
   end

   // Main state registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a behavioural model.
// Define PC_RAS_EN for both files to exercise the return-address stack.
module tb_pc_gen;

   localparam int          XLEN  = 32;
   localparam logic [31:0] RV    = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc, pc_plus4;
   logic        fetch_valid, fetch_ready;
   logic        trap_valid, br_valid, halt;
   logic [31:0] trap_vector, br_target;
   logic        misalign_err;
   logic        ras_push, ras_pop, ras_empty;
   logic [31:0] ras_push_addr;

   pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_pc     (fetch_pc),
      .pc_plus4     (pc_plus4),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .trap_valid   (trap_valid),
      .trap_vector  (trap_vector),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .halt         (halt),
      .misalign_err (misalign_err),
      .ras_push     (ras_push),
      .ras_push_addr(ras_push_addr),
      .ras_pop      (ras_pop),
      .ras_empty    (ras_empty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: "booting" cycle flag, "running" vs halted, PC, flag, stack.
   bit          m_boot;
   bit          m_run;
   logic [31:0] m_pc;
   bit          m_mis;
   logic [31:0] m_ras[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1;
      m_run  = 1'b0;
      m_pc   = RV;
      m_mis  = 1'b0;
      m_ras.delete();
   endtask

   task automatic compare_outputs();
      check("fetch_pc", fetch_pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("fetch_valid", 32'(fetch_valid), 32'(m_run));
      check("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef PC_RAS_EN
      check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
`else
      check("ras_empty", 32'(ras_empty), 32'd1);
`endif
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit          pop_ok;
      logic [31:0] nxt;
      if (m_boot) begin
         m_boot = 1'b0;
         m_run  = 1'b1;
         m_mis  = 1'b0;
         return;
      end
      pop_ok = 1'b0;
`ifdef PC_RAS_EN
      pop_ok = ras_pop && (m_ras.size() > 0);
`endif
      nxt   = m_pc;
      m_mis = 1'b0;
      if (trap_valid) begin
         nxt   = trap_vector & ~32'd3;
         m_mis = (trap_vector % 4) != 0;
      end else if (br_valid) begin
         nxt   = br_target & ~32'd3;
         m_mis = (br_target % 4) != 0;
      end else if (pop_ok) begin
         nxt = m_ras[$];
      end else if (m_run && fetch_ready) begin
         nxt = m_pc + 32'd4;
      end
`ifdef PC_RAS_EN
      if (!trap_valid && !br_valid && pop_ok) begin
         if (ras_push) m_ras[m_ras.size() - 1] = ras_push_addr;
         else void'(m_ras.pop_back());
      end else if (ras_push) begin
         m_ras.push_back(ras_push_addr);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
`endif
      if (m_run && halt && fetch_ready) m_run = 1'b0;
      else if (!m_run && !halt) m_run = 1'b1;
      m_pc = nxt;
   endtask

   // Inputs are driven just after an edge; check, step model, cross one edge.
   task automatic cycle();
      #1;
      compare_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic branch(input logic [31:0] tgt);
      br_valid  = 1'b1;
      br_target = tgt;
      cycle();
      br_valid  = 1'b0;
   endtask

   // Asynchronous reset pulse between two edges.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check("async_rst_pc", fetch_pc, RV);
      check("async_rst_valid", 32'(fetch_valid), 32'd0);
      check("async_rst_mis", 32'(misalign_err), 32'd0);
      check("async_rst_empty", 32'(ras_empty), 32'd1);
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      fetch_ready = 1'b1;
      trap_valid = 1'b0; trap_vector = '0;
      br_valid = 1'b0;   br_target = '0;
      halt = 1'b0;
      ras_push = 1'b0;   ras_push_addr = '0;
      ras_pop = 1'b0;
      model_reset();

      // Reset and boot sequence.
      repeat (2) @(posedge clk);
      #1;
      compare_outputs();
      check("reset_valid", 32'(fetch_valid), 32'd0);
      #2 rst = 1'b0;
      cycle();
      check("boot_pc0", fetch_pc, 32'h100);
      cycle();
      check("boot_pc1", fetch_pc, 32'h104);
      cycle();
      check("boot_pc2", fetch_pc, 32'h108);

      // Backpressure holds the PC.
      branch(32'h200);
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_pc", fetch_pc, 32'h200);
         check("stall_valid", 32'(fetch_valid), 32'd1);
      end
      fetch_ready = 1'b1;
      cycle();
      check("stall_release", fetch_pc, 32'h204);

      // Wrap at the top of the address space.
      branch(32'hFFFF_FFFC);
      cycle();
      check("wrap", fetch_pc, 32'h0);

      // Priority: trap over branch over pop.
      trap_valid = 1'b1; trap_vector = 32'h80;
      br_valid = 1'b1;   br_target = 32'h400;
      ras_pop = 1'b1;
      cycle();
      trap_valid = 1'b0; br_valid = 1'b0; ras_pop = 1'b0;
      check("priority", fetch_pc, 32'h80);

      // Misaligned branch target.
      branch(32'h403);
      check("mis_pc", fetch_pc, 32'h400);
      check("mis_pulse", 32'(misalign_err), 32'd1);
      cycle();
      check("mis_clear", 32'(misalign_err), 32'd0);

      // Halt during a stalled request, redirect while halted, resume.
      fetch_ready = 1'b0;
      halt = 1'b1;
      repeat (2) cycle();
      check("halt_pending_valid", 32'(fetch_valid), 32'd1);
      fetch_ready = 1'b1;
      cycle();
      check("halted_valid", 32'(fetch_valid), 32'd0);
      cycle();
      check("halted_stay", 32'(fetch_valid), 32'd0);
      branch(32'h600);
      check("halted_br_pc", fetch_pc, 32'h600);
      check("halted_br_valid", 32'(fetch_valid), 32'd0);
      halt = 1'b0;
      cycle();
      check("resume_pc", fetch_pc, 32'h600);
      check("resume_valid", 32'(fetch_valid), 32'd1);
      cycle();
      check("resume_next", fetch_pc, 32'h604);

`ifdef PC_RAS_EN
      // Overfill the stack, then drain it.
      for (int i = 1; i <= 5; i++) begin
         ras_push = 1'b1;
         ras_push_addr = 32'(i * 16);
         cycle();
      end
      ras_push = 1'b0;
      ras_pop = 1'b1;
      for (int i = 5; i >= 2; i--) begin
         cycle();
         check("ras_pop_pc", fetch_pc, 32'(i * 16));
      end
      cycle();
      check("ras_pop_empty_pc", fetch_pc, 32'h24);
      check("ras_drained", 32'(ras_empty), 32'd1);
      ras_pop = 1'b0;
      ras_push = 1'b1; ras_push_addr = 32'h60;
      cycle();
      ras_push_addr = 32'h70; ras_pop = 1'b1;
      cycle();
      check("ras_swap_pc", fetch_pc, 32'h60);
      ras_push = 1'b0;
      cycle();
      check("ras_swap_top", fetch_pc, 32'h70);
      ras_pop = 1'b0;
`endif

      // Async reset while stalled with a branch pending.
      fetch_ready = 1'b0;
      br_valid = 1'b1; br_target = 32'h700;
      async_reset();
      cycle();
      check("post_rst_pc", fetch_pc, RV);
      br_valid = 1'b0;
      fetch_ready = 1'b1;
      cycle();
      check("post_rst_next", fetch_pc, RV + 32'd4);

      // Random stimulus against the model.
      for (int n = 0; n < 800; n++) begin
         trap_valid    = ($urandom_range(0, 19) == 0);
         trap_vector   = $urandom;
         br_valid      = ($urandom_range(0, 7) == 0);
         br_target     = $urandom;
         fetch_ready   = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) halt = ~halt;
         ras_push      = ($urandom_range(0, 3) == 0);
         ras_push_addr = $urandom;
         ras_pop       = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) async_reset();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
